alarm_clock_multi: RTL and testbench
====================================

Name: alarm_clock_multi

Overview:
- 24-hour BCD time-of-day clock with NUM_ALARMS independently programmable alarm channels, snooze and auto-timeout.
- Parametrised successor to the single-alarm clock block. Adds a minute prescaler, an alarm table, per-channel enables, a snooze timer and an acknowledge input.
- Drives the HH:MM display digits and the alarm LED in the clock subsystem.

Parameters:
- TICKS_PER_MIN, 60, clk cycles per minute; must be >= 1. Simulation uses 2.
- NUM_ALARMS, 4, number of alarm channels; range 1..16.
- IDX_W, 2, width of the channel index; must satisfy 2^IDX_W >= NUM_ALARMS.
- LED_MINUTES, 1, minutes an unacknowledged alarm stays active before auto-clear; must be >= 1.
- SNOOZE_MIN, 5, minutes from snooze until the snoozed channels re-fire; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write one alarm table entry this cycle.
- wr_idx  in  IDX_W  channel to write.
- hr1  in  2  alarm hour tens digit (BCD).
- hr0  in  4  alarm hour units digit (BCD).
- min1  in  3  alarm minute tens digit (BCD).
- min0  in  4  alarm minute units digit (BCD).
- wr_ena  in  1  enable bit written with the entry.
- ack  in  1  clear all active and snoozed alarms.
- snooze  in  1  snooze the currently active alarms.
- cnt3  out  2  time hour tens digit.
- cnt2  out  4  time hour units digit.
- cnt1  out  3  time minute tens digit.
- cnt0  out  4  time minute units digit.
- led_on  out  1  OR of all active flags.
- alm_hit  out  NUM_ALARMS  per-channel active flags.
- wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - rst takes priority over every other input.
  - Reset values: time 00:00; prescaler 0; all table entries 00:00 and disabled; alm_hit, snooze flags and all counters 0; led_on 0; wr_err 0.
  - Reset mid-alarm clears the alarm immediately at that edge.
- Prescaler:
  - Counts 0..TICKS_PER_MIN-1.
  - min_tick is asserted in the cycle where the count equals TICKS_PER_MIN-1; the count wraps to 0 at that edge.
  - Time advances on the same edge.
- Time counting (BCD, at each min_tick):
  - cnt0 wraps 9->0 with carry into cnt1.
  - cnt1 wraps 5->0 with carry into the hour digits.
  - Hours count 00..23; 09->10, 19->20, 23:59->00:00.
  - No digit ever holds an illegal BCD value.
- Alarm writes:
  - Accepted only if hour <= 23, minute <= 59, each digit is legal BCD, and wr_idx < NUM_ALARMS.
  - Otherwise the table is unchanged and wr_err pulses high for exactly the next cycle.
  - A write takes effect at the clock edge.
  - A match evaluated in the same cycle uses the old entry.
- Match detection:
  - Evaluated only in the cycle after the time changes, i.e. on minute transitions.
  - Enabled channel i matching the new time sets alm_hit[i] at the following edge.
  - Result: led_on rises 1 clk after cnt* changes.
  - Time equal to an alarm at reset or at write does not fire.
  - Multiple channels may match together; all are set.
- Active timeout:
  - While any alm_hit bit is set, a minute counter counts min_ticks.
  - After LED_MINUTES ticks, all alm_hit bits clear.
  - The counter restarts whenever a new channel becomes active.
- Snooze:
  - snooze=1 with led_on=1 copies alm_hit into the snooze mask, clears alm_hit and loads the snooze counter with SNOOZE_MIN.
  - The snooze counter decrements on each min_tick. On reaching 0, the mask is ORed into alm_hit (restarting timeout) and the mask clears.
  - snooze while led_on=0 is ignored.
  - A second snooze during a pending snooze merges the masks and reloads the counter.
- ack:
  - Clears alm_hit, the snooze mask and both counters at the next edge.
- Same-cycle priority: rst > ack > snooze > new match.
  - A match in the same cycle as ack is still set, because a new event is not lost.
  - A match in the same cycle as snooze is ORed into alm_hit after the snooze capture and is not snoozed.
- Disabling a channel by write does not clear an already-active alm_hit bit.
- led_on = |alm_hit, registered.

Test Plan (TICKS_PER_MIN=2, NUM_ALARMS=4, LED_MINUTES=1, SNOOZE_MIN=5):
- Reset, then run 2880 cycles -> time reaches 23:59 then 00:00. Digits pass 09:59->10:00 and 19:59->20:00. No illegal BCD values.
- Write ch0=03:55 enabled -> alm_hit=4'b0001 and led_on=1 exactly 1 clk after cnt*=03:55. Both clear 2 clks later (1 minute) with no ack.
- Write ch1 and ch2 both =16:08 enabled, ch3=16:08 disabled -> alm_hit=4'b0110 at 16:08. ack asserted 1 cycle later -> alm_hit=0 next edge.
- Alarm ch0 at 01:00 active, then snooze -> led_on=0 next edge. led_on re-rises with alm_hit=4'b0001 when the time reaches 01:05. A second ack clears it.
- Write hr1=2,hr0=4,min1=0,min0=0 and a separate write with min0=4'd10 -> wr_err pulses each time and the table is unchanged. Write wr_idx=3 legally -> no wr_err.
- Assert rst while led_on=1 at 03:55 -> next edge shows time 00:00, led_on=0, all channels disabled. Running to 03:55 again does not fire.

Source files
------------

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour BCD time-of-day clock with NUM_ALARMS alarm channels.
//   A prescaler produces one min_tick every TICKS_PER_MIN cycles and the HH:MM
//   digits advance on that edge. Each channel holds an HH:MM entry and an
//   enable bit. In the cycle after a minute change, every enabled channel whose
//   entry equals the new time raises its alm_hit bit. Active alarms auto-clear
//   after LED_MINUTES minutes, can be snoozed for SNOOZE_MIN minutes, or
//   cleared with ack.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   wr_en, wr_idx          alarm table write strobe and channel index
//   hr1, hr0, min1, min0   alarm entry digits (BCD); wr_ena is the enable bit
//   ack, snooze            clear-all / snooze the active alarms
//   cnt3..cnt0             time digits HH:MM
//   led_on, alm_hit        any-alarm LED, per-channel active flags
//   wr_err                 one-cycle pulse after a rejected write

// One alarm channel: the stored entry plus its comparator.
module alarm_clock_multi_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [12:0] ent_i,
  input  logic        ena_i,
  input  logic        chk_i,
  input  logic [12:0] tm_i,
  output logic        hit_o
);
  logic [12:0] ent_q;
  logic        ena_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      ena_q <= 1'b0;
    end else if (we_i) begin
      ent_q <= ent_i;
      ena_q <= ena_i;
    end
  end

  // chk_i is high only in the cycle right after a minute change.
  assign hit_o = chk_i & ena_q & (ent_q == tm_i);
endmodule

module alarm_clock_multi #(
  parameter int TICKS_PER_MIN = 60,
  parameter int NUM_ALARMS    = 4,
  parameter int IDX_W         = 2,
  parameter int LED_MINUTES   = 1,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [1:0]            hr1,
  input  logic [3:0]            hr0,
  input  logic [2:0]            min1,
  input  logic [3:0]            min0,
  input  logic                  wr_ena,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [1:0]            cnt3,
  output logic [3:0]            cnt2,
  output logic [2:0]            cnt1,
  output logic [3:0]            cnt0,
  output logic                  led_on,
  output logic [NUM_ALARMS-1:0] alm_hit,
  output logic                  wr_err
);
  localparam int PS_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int TO_W = $clog2(LED_MINUTES + 1);
  localparam int SN_W = $clog2(SNOOZE_MIN + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_MIN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LED_MINUTES - 1);
  localparam logic [SN_W-1:0] SN_FULL = SN_W'(SNOOZE_MIN);

  // ---------------- prescaler ----------------
  logic [PS_W-1:0] presc_q, presc_d;
  logic            min_tick;

  assign min_tick = (presc_q == PS_LAST);
  assign presc_d  = min_tick ? '0 : presc_q + PS_W'(1);

  // ---------------- time of day ----------------
  logic [1:0] c3_q, c3_d;
  logic [3:0] c2_q, c2_d;
  logic [2:0] c1_q, c1_d;
  logic [3:0] c0_q, c0_d;
  logic       tchg_q;

  always_comb begin
    c3_d = c3_q;
    c2_d = c2_q;
    c1_d = c1_q;
    c0_d = c0_q;
    if (min_tick) begin
      if (c0_q == 4'd9) begin
        c0_d = 4'd0;
        if (c1_q == 3'd5) begin
          c1_d = 3'd0;
          if (c3_q == 2'd2 && c2_q == 4'd3) begin
            c3_d = 2'd0;
            c2_d = 4'd0;
          end else if (c2_q == 4'd9) begin
            c2_d = 4'd0;
            c3_d = c3_q + 2'd1;
          end else begin
            c2_d = c2_q + 4'd1;
          end
        end else begin
          c1_d = c1_q + 3'd1;
        end
      end else begin
        c0_d = c0_q + 4'd1;
      end
    end
  end

  assign cnt3 = c3_q;
  assign cnt2 = c2_q;
  assign cnt1 = c1_q;
  assign cnt0 = c0_q;

  // ---------------- alarm table ----------------
  logic                  wr_ok;
  logic                  idx_ok;
  logic [NUM_ALARMS-1:0] match;

  assign idx_ok = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_ALARMS));
  assign wr_ok  = ((hr1 < 2'd2) ? (hr0 <= 4'd9) : (hr1 == 2'd2 && hr0 <= 4'd3)) &&
                  (min1 <= 3'd5) && (min0 <= 4'd9) && idx_ok;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_clock_multi_chan u_ch (
      .clk   (clk),
      .rst   (rst),
      .we_i  (wr_en && wr_ok && (wr_idx == IDX_W'(i))),
      .ent_i ({hr1, hr0, min1, min0}),
      .ena_i (wr_ena),
      .chk_i (tchg_q),
      .tm_i  ({c3_q, c2_q, c1_q, c0_q}),
      .hit_o (match[i])
    );
  end

  // ---------------- active / snooze control ----------------
  logic [NUM_ALARMS-1:0] alm_q, alm_d;
  logic [NUM_ALARMS-1:0] msk_q, msk_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [SN_W-1:0]       sn_q, sn_d;
  logic                  led_q;
  logic                  err_q;

  always_comb begin
    alm_d = alm_q;
    msk_d = msk_q;
    to_d  = to_q;
    sn_d  = sn_q;
    if (ack) begin
      // A match landing with ack is a fresh event and is kept.
      alm_d = match;
      msk_d = '0;
      to_d  = '0;
      sn_d  = '0;
    end else if (snooze && led_q) begin
      msk_d = msk_q | alm_q;
      alm_d = '0;
      to_d  = '0;
      // A minute boundary in the capture cycle already counts toward the snooze.
      sn_d  = min_tick ? SN_FULL - SN_W'(1) : SN_FULL;
      if (sn_d == '0) begin
        alm_d = msk_d;
        msk_d = '0;
      end
      // Matches this cycle are not snoozed.
      alm_d = alm_d | match;
    end else begin
      if ((|alm_q) && min_tick) begin
        if (to_q == TO_LAST) begin
          alm_d = '0;
          to_d  = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      if ((|msk_q) && min_tick) begin
        if (sn_q <= SN_W'(1)) begin
          alm_d = alm_d | msk_q;
          msk_d = '0;
          sn_d  = '0;
          to_d  = '0;
        end else begin
          sn_d = sn_q - SN_W'(1);
        end
      end
      if (|(match & ~alm_d)) to_d = '0;
      alm_d = alm_d | match;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      c3_q    <= '0;
      c2_q    <= '0;
      c1_q    <= '0;
      c0_q    <= '0;
      tchg_q  <= 1'b0;
      alm_q   <= '0;
      msk_q   <= '0;
      to_q    <= '0;
      sn_q    <= '0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      c3_q    <= c3_d;
      c2_q    <= c2_d;
      c1_q    <= c1_d;
      c0_q    <= c0_d;
      tchg_q  <= min_tick;
      alm_q   <= alm_d;
      msk_q   <= msk_d;
      to_q    <= to_d;
      sn_q    <= sn_d;
      // LED tracks the next alarm state so it rises together with alm_hit.
      led_q   <= |alm_d;
      err_q   <= wr_en & ~wr_ok;
    end
  end

  assign alm_hit = alm_q;
  assign led_on  = led_q;
  assign wr_err  = err_q;
endmodule

// File: tb/tb_alarm_clock_multi.sv
module tb_alarm_clock_multi;
  logic       clk = 1'b0;
  logic       rst, wr_en, wr_ena, ack, snooze;
  logic [1:0] wr_idx;
  logic [1:0] hr1;
  logic [3:0] hr0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [1:0] cnt3;
  logic [3:0] cnt2;
  logic [2:0] cnt1;
  logic [3:0] cnt0;
  logic       led_on, wr_err;
  logic [3:0] alm_hit;

  int n_run = 0;
  int n_fail = 0;

  alarm_clock_multi #(
    .TICKS_PER_MIN(2), .NUM_ALARMS(4), .IDX_W(2), .LED_MINUTES(1), .SNOOZE_MIN(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .wr_ena(wr_ena),
    .ack(ack), .snooze(snooze),
    .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
    .led_on(led_on), .alm_hit(alm_hit), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] tm();
    return {cnt3, cnt2, cnt1, cnt0};
  endfunction

  function automatic logic [12:0] hm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input int h1, input int h0, input int m1,
                    input int m0, input logic en);
    wr_en = 1'b1; wr_idx = 2'(idx); hr1 = 2'(h1); hr0 = 4'(h0);
    min1 = 3'(m1); min0 = 4'(m0); wr_ena = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_tm(input logic [12:0] t, input string tag);
    int n = 0;
    while (tm() != t && n < 4000) begin
      step();
      n++;
    end
    chk(tag, 32'(tm()), 32'(t));
  endtask

  initial begin
    int errs, bad, leds;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; hr1 = '0; hr0 = '0; min1 = '0;
    min0 = '0; wr_ena = 1'b0; ack = 1'b0; snooze = 1'b0;
    repeat (3) step();
    chk("rst_time", 32'(tm()), 32'(hm(0, 0)));
    chk("rst_led", 32'(led_on), 32'd0);
    chk("rst_alm", 32'(alm_hit), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    rst = 1'b0;

    // Full day: time after n edges is n/2 minutes.
    errs = 0; bad = 0;
    for (int n = 1; n <= 2880; n++) begin
      step();
      if (tm() != hm(((n / 2) % 1440) / 60, ((n / 2) % 1440) % 60)) errs++;
      if (cnt0 > 4'd9 || cnt1 > 3'd5 || cnt2 > 4'd9 || cnt3 > 2'd2 ||
          (cnt3 == 2'd2 && cnt2 > 4'd3)) bad++;
      if (n == 1200) chk("t_1000", 32'(tm()), 32'(hm(10, 0)));
      if (n == 2400) chk("t_2000", 32'(tm()), 32'(hm(20, 0)));
      if (n == 2878) chk("t_2359", 32'(tm()), 32'(hm(23, 59)));
    end
    chk("day_model", errs, 0);
    chk("day_bcd", bad, 0);
    chk("day_wrap", 32'(tm()), 32'(hm(0, 0)));

    // Single alarm with auto-timeout.
    wr(0, 0, 3, 5, 5, 1'b1);
    chk("wr0_err", 32'(wr_err), 32'd0);
    wait_tm(hm(3, 55), "wait_0355");
    chk("a0_pre", 32'(alm_hit), 32'd0);
    step();
    chk("a0_hit", 32'(alm_hit), 32'b0001);
    chk("a0_led", 32'(led_on), 32'd1);
    step();
    chk("a0_to_alm", 32'(alm_hit), 32'd0);
    chk("a0_to_led", 32'(led_on), 32'd0);

    // Legal writes, then rejected writes aimed at the same channels.
    wr(1, 1, 6, 0, 8, 1'b1);
    wr(2, 1, 6, 0, 8, 1'b1);
    wr(3, 1, 6, 0, 8, 1'b0);
    chk("wr3_err", 32'(wr_err), 32'd0);
    wr(1, 2, 4, 0, 0, 1'b0);
    chk("bad24_err", 32'(wr_err), 32'd1);
    step();
    chk("bad24_pulse", 32'(wr_err), 32'd0);
    wr(2, 1, 6, 0, 10, 1'b0);
    chk("badm0_err", 32'(wr_err), 32'd1);
    step();
    chk("badm0_pulse", 32'(wr_err), 32'd0);

    // Two channels fire together, then ack.
    wait_tm(hm(16, 8), "wait_1608");
    step();
    chk("multi_hit", 32'(alm_hit), 32'b0110);
    chk("multi_led", 32'(led_on), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("multi_ack", 32'(alm_hit), 32'd0);

    // Snooze at 01:00 re-fires at 01:05.
    wr(0, 0, 1, 0, 0, 1'b1);
    wait_tm(hm(1, 0), "wait_0100");
    step();
    chk("sz_hit", 32'(alm_hit), 32'b0001);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("sz_led_off", 32'(led_on), 32'd0);
    chk("sz_alm_off", 32'(alm_hit), 32'd0);
    wait_tm(hm(1, 4), "wait_0104");
    chk("sz_quiet", 32'(led_on), 32'd0);
    wait_tm(hm(1, 5), "wait_0105");
    chk("sz_refire", 32'(alm_hit), 32'b0001);
    chk("sz_refire_led", 32'(led_on), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sz_ack_alm", 32'(alm_hit), 32'd0);
    chk("sz_ack_led", 32'(led_on), 32'd0);
    step();
    chk("sz_ack_stay", 32'(led_on), 32'd0);

    // ack during a pending snooze drops it.
    wr(3, 0, 2, 0, 0, 1'b1);
    wait_tm(hm(2, 0), "wait_0200");
    step();
    chk("sa_hit", 32'(alm_hit), 32'b1000);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    wait_tm(hm(2, 5), "wait_0205");
    chk("sa_none", 32'(alm_hit), 32'd0);
    step();
    chk("sa_none_led", 32'(led_on), 32'd0);

    // Reset while an alarm is active.
    wr(0, 0, 3, 5, 5, 1'b1);
    wait_tm(hm(3, 55), "wait_0355b");
    step();
    chk("rr_led", 32'(led_on), 32'd1);
    rst = 1'b1;
    step();
    chk("rr_time", 32'(tm()), 32'(hm(0, 0)));
    chk("rr_led_off", 32'(led_on), 32'd0);
    chk("rr_alm_off", 32'(alm_hit), 32'd0);
    rst = 1'b0;
    leds = 0;
    for (int n = 0; n < 474; n++) begin
      step();
      if (led_on || alm_hit != 4'd0) leds++;
    end
    chk("rr_no_fire", leds, 0);
    chk("rr_time_0357", 32'(tm()), 32'(hm(3, 57)));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
